div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle 32-bit integer divider sequencer for the HI/LO path. It accepts a DIV/DIVU issued from EX and runs a radix-2 restoring division, one quotient bit per cycle. While it runs, it holds the pipeline through the stall controller, then presents the result for one cycle on the same 66-bit HI/LO bus format that MEM and WB carry (`{hi_we, lo_we, hi, lo}`). It sits beside EX and feeds the EX→MEM HI/LO bus.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; the HI/LO bus is `2*WIDTH+2` bits.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  EX presents a divide this cycle; sampled only in IDLE.
- `signed_op`  in  1  1 = DIV (signed), 0 = DIVU.
- `dividend`  in  WIDTH  rs value, sampled with `start`.
- `divisor`  in  WIDTH  rt value, sampled with `start`.
- `cancel`  in  1  flush; aborts any operation in progress.
- `stallreq`  out  1  request to the stall controller to freeze IF..EX.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `div_to_hilo_bus`  out  66  `{hi_we, lo_we, hi(remainder), lo(quotient)}`; all-zero unless `done`.

## Operation
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - `start` & `divisor==0` → ZERO.
  - `start` & `divisor!=0` → RUN. Latch `|dividend|`, `|divisor|` (two's-complement magnitude if `signed_op`, raw otherwise), the sign of the quotient (`dividend[31]^divisor[31]`) and the sign of the remainder (`dividend[31]`). Clear the 6-bit counter and the 33-bit partial remainder.
- RUN, each cycle:
  - Shift `{rem, quo}` left 1.
  - Trial-subtract the divisor from the upper 33 bits. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore.
  - Counter +1. After the iteration with counter==31 → DONE.
- ZERO: one cycle → DONE with lo=0xFFFFFFFF, hi=dividend. Fixed defined value for divide-by-zero.
- DONE:
  - Result fixup: negate the quotient if the quotient sign is set and `signed_op`; negate the remainder if the remainder sign is set and `signed_op`.
  - Drive `hi_we=lo_we=1` and `done=1`, then → IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF produces lo=0x80000000, hi=0. This falls out of the magnitude arithmetic modulo 2^32 and needs no special case.
- `cancel` in any state → IDLE next edge. `done` does not pulse and the bus stays zero. `cancel` has priority over the DONE output, which is suppressed in that cycle. `cancel` with `start` in IDLE: no operation starts.
- `start` while not IDLE is ignored; operands are not re-latched.
- `rst` asserted at any time → IDLE immediately (async). Counter, operands and partial remainder are cleared.

## Timing
- Reset values: `stallreq=0`, `busy=0`, `done=0`, `div_to_hilo_bus=0`, state=IDLE.
- `stallreq` is combinational: high in IDLE when `start & ~cancel`, and high in RUN and ZERO. It is low in DONE, so the pipeline advances on the DONE edge and EX captures the bus.
- Latency, with `start` sampled at edge 0:
  - Nonzero divisor: RUN for edges 1..32, DONE during the cycle after edge 32. `done` is high 33 cycles after `start`.
  - Zero divisor: ZERO for one cycle, `done` 2 cycles after `start`.
- `busy` is registered from state.
- The output bus is combinational from DONE-state registers and is stable for the whole DONE cycle.
- A back-to-back `start` is accepted in the IDLE cycle directly following DONE. No extra gap is required.

## Test plan
- Unsigned 7/2, `start` 1 cycle → `stallreq` high for 33 cycles; `done` at cycle 33; bus = {1,1,0x00000001,0x00000003}.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned 0xFFFFFFFF/1 → lo=0xFFFFFFFF, hi=0.
- Signed 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0; 33-cycle latency.
- Divisor 0, dividend 0x12345678 → `done` 2 cycles after `start`; lo=0xFFFFFFFF, hi=0x12345678.
- `cancel` at RUN cycle 10 → IDLE next edge; `busy`/`stallreq` low; no `done`; bus stays 0. A new `start` the next cycle completes correctly.
- `rst` pulsed mid-RUN (async, between edges) → all outputs 0 immediately. A second `start` during RUN is ignored: the result matches the first operands.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for the HI/LO path.
// Accepts DIV/DIVU from EX, stalls IF..EX while iterating one quotient bit
// per cycle, then presents {hi_we, lo_we, hi, lo} for exactly one cycle.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               cancel,
  output logic               stallreq,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH+1:0] div_to_hilo_bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next;
  logic [CW-1:0]    cnt_r;
  // Partial remainder; the extra (33rd) bit of the trial lives in shifted_s.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic             busy_r;

  logic             accept_s;
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] lo_s;

  // Two's-complement magnitude when the operation is signed, raw otherwise.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // Conditional negation used for the final sign fixup.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    if (neg) begin
      apply_sign = -v;
    end else begin
      apply_sign = v;
    end
  endfunction

  assign accept_s  = (state_r == IDLE) && start && !cancel;
  assign shifted_s = {rem_r, quo_r[WIDTH-1]};
  assign trial_s   = shifted_s - {1'b0, dvsr_r};

  // Next-state logic; cancel always returns to IDLE.
  always_comb begin
    state_next = IDLE;
    if (cancel) begin
      state_next = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_next = (divisor == '0) ? ZERO : RUN;
          end else begin
            state_next = IDLE;
          end
        end
        ZERO:    state_next = DONE;
        RUN: begin
          if (cnt_r == LAST_ITER) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next;
      busy_r  <= (state_next != IDLE);
    end
  end

  // Operand latch and one restoring-division iteration per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr_r    <= '0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r <= '0;
            if (divisor == '0) begin
              // Divide-by-zero: fixed result lo=all ones, hi=dividend.
              quo_r     <= {WIDTH{1'b1}};
              rem_r     <= dividend;
              dvsr_r    <= '0;
              neg_q_r   <= 1'b0;
              neg_rem_r <= 1'b0;
            end else begin
              quo_r     <= magnitude(dividend, signed_op);
              rem_r     <= '0;
              dvsr_r    <= magnitude(divisor, signed_op);
              neg_q_r   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_rem_r <= signed_op & dividend[WIDTH-1];
            end
          end
        end
        RUN: begin
          if (!trial_s[WIDTH]) begin
            rem_r <= trial_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= shifted_s[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Stall request and result bus, derived from the current state.
  always_comb begin
    stallreq        = 1'b0;
    done            = 1'b0;
    hi_s            = apply_sign(rem_r, neg_rem_r);
    lo_s            = apply_sign(quo_r, neg_q_r);
    div_to_hilo_bus = '0;
    case (state_r)
      IDLE:      stallreq = start & ~cancel;
      ZERO, RUN: stallreq = 1'b1;
      DONE: begin
        stallreq = 1'b0;
        done     = ~cancel;
      end
      default:   stallreq = 1'b0;
    endcase
    if (done) begin
      div_to_hilo_bus = {2'b11, hi_s, lo_s};
    end else begin
      div_to_hilo_bus = '0;
    end
  end

  assign busy = busy_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: a transaction-level reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic        cancel = 1'b0;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [65:0] div_to_hilo_bus;

  int n_checks = 0;
  int n_fail = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .stallreq(stallreq), .busy(busy), .done(done),
    .div_to_hilo_bus(div_to_hilo_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa = a; sb = b;
    q = sa / sb; r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // Transaction model: cycles left before the result, and result pending.
  int          m_left = 0;
  bit          m_in_done = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Model update on each clock edge, async clear on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_in_done <= 1'b0;
    end else if (cancel) begin
      m_left <= 0; m_in_done <= 1'b0;
    end else if (m_in_done) begin
      m_in_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_in_done <= 1'b1;
    end else if (start) begin
      {m_hi, m_lo} <= ref_div(dividend, divisor, signed_op);
      m_left <= (divisor == 32'd0) ? 1 : 32;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    logic e_busy, e_stall, e_done;
    logic [65:0] e_bus;
    e_busy  = (m_left > 0) || m_in_done;
    e_stall = (m_left > 0) || (!m_in_done && start && !cancel && !rst);
    e_done  = m_in_done && !cancel;
    e_bus   = e_done ? {2'b11, m_hi, m_lo} : 66'd0;
    chk("m_busy", 66'(busy), 66'(e_busy));
    chk("m_stallreq", 66'(stallreq), 66'(e_stall));
    chk("m_done", 66'(done), 66'(e_done));
    chk("m_bus", div_to_hilo_bus, e_bus);
  end

  // Issue a divide now (caller is just after a rising edge) and check it.
  task automatic run_div_now(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic [31:0] ehi, input logic [31:0] elo,
                             input int elat, input int estall, input int extra_at,
                             input bit check_idle);
    int stalls; bit got; logic [65:0] cap; int lat;
    stalls = 0; got = 1'b0; cap = 66'd0; lat = -1;
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0 && check_idle) chk({name, "_idle_busy"}, 66'(busy), 66'(0));
      if (stallreq) stalls++;
      if (done) begin got = 1'b1; cap = div_to_hilo_bus; lat = i; break; end
      @(posedge clk); #1;
      if (i + 1 == extra_at) begin
        start = 1'b1; dividend = 32'h00000064; divisor = 32'h00000003; signed_op = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    chk({name, "_seen"}, 66'(got), 66'(1));
    chk({name, "_latency"}, 66'(lat), 66'(elat));
    chk({name, "_bus"}, cap, {2'b11, ehi, elo});
    if (estall >= 0) chk({name, "_stall_cycles"}, 66'(stalls), 66'(estall));
  endtask

  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] ehi, input logic [31:0] elo,
                         input int elat);
    @(posedge clk); #1;
    run_div_now(name, a, b, s, ehi, elo, elat, -1, -1, 1'b0);
  endtask

  initial begin
    // Pin the reference model with hand-computed results.
    chk("ref_u7_2", {2'b00, ref_div(32'd7, 32'd2, 1'b0)}, {2'b00, 32'h1, 32'h3});
    chk("ref_sm7_2", {2'b00, ref_div(32'hFFFFFFF9, 32'd2, 1'b1)}, {2'b00, 32'hFFFFFFFF, 32'hFFFFFFFD});
    chk("ref_ovf", {2'b00, ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1)}, {2'b00, 32'h0, 32'h80000000});
    chk("ref_dz", {2'b00, ref_div(32'h12345678, 32'd0, 1'b1)}, {2'b00, 32'h12345678, 32'hFFFFFFFF});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stallreq", 66'(stallreq), 66'(0));
    chk("rst_busy", 66'(busy), 66'(0));
    chk("rst_done", 66'(done), 66'(0));
    chk("rst_bus", div_to_hilo_bus, 66'd0);
    rst = 1'b0;

    // Main function, latency and stall length.
    @(posedge clk); #1;
    run_div_now("u7_2", 32'd7, 32'd2, 1'b0, 32'h1, 32'h3, 33, 33, -1, 1'b0);
    run_div("sm7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_div("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'hFFFFFFFF, 33);
    run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h80000000, 33);
    run_div("u_ovf_pat", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'h0, 33);
    run_div("s100_m7", 32'd100, 32'hFFFFFFF9, 1'b1, 32'h2, 32'hFFFFFFF2, 33);
    run_div("sm100_7", 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFF2, 33);
    run_div("u_big_div", 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h0, 33);
    run_div("dz_u", 32'h12345678, 32'd0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 2);
    run_div("dz_s", 32'h80000001, 32'd0, 1'b1, 32'h80000001, 32'hFFFFFFFF, 2);

    // Cancel during RUN cycle 10, then a new start in the very next cycle.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    run_div_now("after_cancel", 32'd1000, 32'd7, 1'b0, 32'h6, 32'd142, 33, -1, -1, 1'b1);

    // Cancel in the DONE cycle suppresses the result.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'h55; divisor = 32'd0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; cancel = 1'b1;
    @(negedge clk);
    chk("cxl_done_done", 66'(done), 66'(0));
    chk("cxl_done_bus", div_to_hilo_bus, 66'd0);
    @(posedge clk); #1; cancel = 1'b0;
    @(negedge clk);
    chk("cxl_done_busy", 66'(busy), 66'(0));

    // Cancel together with start in IDLE: nothing starts.
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd5;
    @(negedge clk);
    chk("cxl_start_stall", 66'(stallreq), 66'(0));
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    chk("cxl_start_busy", 66'(busy), 66'(0));

    // Asynchronous reset mid-RUN clears outputs between edges.
    @(posedge clk); #1;
    start = 1'b1; dividend = 32'h1000; divisor = 32'h10; signed_op = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    chk("arst_stallreq", 66'(stallreq), 66'(0));
    chk("arst_busy", 66'(busy), 66'(0));
    chk("arst_done", 66'(done), 66'(0));
    chk("arst_bus", div_to_hilo_bus, 66'd0);
    #1; rst = 1'b0;

    // Second start during RUN is ignored.
    run_div("ignore_start", 32'd50, 32'd6, 1'b0, 32'h2, 32'h8, 33);
    @(posedge clk); #1;
    run_div_now("ign2", 32'd77, 32'd10, 1'b0, 32'h7, 32'h7, 33, -1, 5, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
